// File: rtl/onchip_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_rom_port_arbiter
//
// Shares one single-port on-chip ROM/RAM (DEPTH words of DATA_W bits) between
// two Avalon-MM masters.
//
// Operation:
//   - Grants are round-robin, with one transaction in flight at a time.
//   - The memory's one-cycle read latency is turned into a registered
//     readdatavalid pulse to the master that issued the read.
//   - Out-of-range accesses are never written to memory.
//   - Out-of-range accesses, and in-range writes made without debugaccess,
//     are counted in a saturating error counter.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   m0_* / m1_*         - Avalon-MM slave ports for the two masters:
//                         read, write, address, byteenable, writedata and
//                         debugaccess in; waitrequest, readdata and
//                         readdatavalid out
//   mem_*               - memory-side command outputs and the memory's q
//                         (mem_readdata in)
//   err_count           - saturating count of rejected accesses
//
// Transaction timeline:
//   IDLE    request sampled and registered
//   ACCEPT  waitrequest low to the winner; memory command driven
//   RDATA   (reads only) memory data captured
// ---------------------------------------------------------------------------
module onchip_rom_port_arbiter #(
    parameter int                ADDR_W   = 12,
    parameter int                DEPTH    = 2560,
    parameter int                DATA_W   = 32,
    parameter int                BE_W     = 4,
    parameter logic [DATA_W-1:0] OOR_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_debugaccess,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_debugaccess,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [15:0]       err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_RDATA  = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     ERR_MAX = 16'hFFFF;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;          // 0 = m0, 1 = m1
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                dbg_q, dbg_d;
    logic                wr_q, wr_d;
    logic                oor_q, oor_d;
    logic                cs_q, cs_d;
    logic                mwr_q, mwr_d;
    logic                wait0_q, wait0_d;
    logic                wait1_q, wait1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [15:0]         err_q, err_d;

    logic                m0_req_s, m1_req_s;
    logic                gsel_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic                sel_wr_s;
    logic                sel_oor_s;
    logic [DATA_W-1:0]   rd_value_s;
    logic                reject_s;

    assign m0_req_s   = m0_read | m0_write;
    assign m1_req_s   = m1_read | m1_write;
    assign sel_addr_s = gsel_s ? m1_address : m0_address;
    // read+write together counts as a write
    assign sel_wr_s   = gsel_s ? m1_write : m0_write;
    assign sel_oor_s  = ({1'b0, sel_addr_s} >= DEPTH_L);
    assign rd_value_s = oor_q ? OOR_DATA : mem_readdata;
    assign reject_s   = oor_q | (wr_q & ~dbg_q);

    // Round-robin pick: on a tie the master that was not granted last wins.
    always_comb begin
        if (m0_req_s & m1_req_s) begin
            gsel_s = ~last_grant_q;
        end else if (m1_req_s) begin
            gsel_s = 1'b1;
        end else begin
            gsel_s = 1'b0;
        end
    end

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        dbg_d        = dbg_q;
        wr_d         = wr_q;
        oor_d        = oor_q;
        cs_d         = 1'b0;
        mwr_d        = 1'b0;
        wait0_d      = 1'b1;
        wait1_d      = 1'b1;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req_s | m1_req_s) begin
                    // The command registers feed mem_* directly in ACCEPT.
                    grant_d = gsel_s;
                    addr_d  = sel_addr_s;
                    be_d    = gsel_s ? m1_byteenable  : m0_byteenable;
                    wdata_d = gsel_s ? m1_writedata   : m0_writedata;
                    dbg_d   = gsel_s ? m1_debugaccess : m0_debugaccess;
                    wr_d    = sel_wr_s;
                    oor_d   = sel_oor_s;
                    cs_d    = 1'b1;
                    mwr_d   = sel_wr_s & ~sel_oor_s;
                    wait0_d = gsel_s;
                    wait1_d = ~gsel_s;
                    state_d = S_ACCEPT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                last_grant_d = grant_q;
                // One increment per access even if both reasons apply.
                if (reject_s && (err_q != ERR_MAX)) begin
                    err_d = err_q + 16'd1;
                end else begin
                    err_d = err_q;
                end
                if (wr_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (grant_q) begin
                    rdata1_d  = rd_value_s;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = rd_value_s;
                    rvalid0_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= {ADDR_W{1'b0}};
            be_q         <= {BE_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            dbg_q        <= 1'b0;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            cs_q         <= 1'b0;
            mwr_q        <= 1'b0;
            wait0_q      <= 1'b1;
            wait1_q      <= 1'b1;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            dbg_q        <= dbg_d;
            wr_q         <= wr_d;
            oor_q        <= oor_d;
            cs_q         <= cs_d;
            mwr_q        <= mwr_d;
            wait0_q      <= wait0_d;
            wait1_q      <= wait1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err_q        <= err_d;
        end
    end

    // Waitrequest is forced high for the whole time reset is asserted,
    // not only after the reset edge.
    assign m0_waitrequest   = wait0_q | reset;
    assign m1_waitrequest   = wait1_q | reset;
    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;
    assign m0_readdatavalid = rvalid0_q;
    assign m1_readdatavalid = rvalid1_q;
    assign mem_address      = addr_q;
    assign mem_byteenable   = be_q;
    assign mem_writedata    = wdata_q;
    assign mem_chipselect   = cs_q;
    assign mem_write        = mwr_q;
    assign mem_debugaccess  = dbg_q;
    assign mem_clken        = 1'b1;
    assign err_count        = err_q;

endmodule
